arb4x32: RTL and testbench
==========================

# arb4x32

Four-requester round-robin arbiter that shares one 32-bit output channel (the 4-way word selector feeding the datapath) among four sources. It picks a winner each cycle and drives the 2-bit select for the shared 4:1 word multiplexer. It also runs a valid/ready handshake on both sides, holds the selection stable until the winning word is accepted, and rotates priority for fairness.

## Interface
Parameters:
- WIDTH, 32, data word width of every input and of the output.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clrn  in  1  reset; synchronous, active-low (sampled on rising clk edge; clrn=0 resets state).
- req  in  4  request/valid per source; bit i qualifies d{i}.
- d0, d1, d2, d3  in  WIDTH  source words.
- gnt  out  4  one-hot accept; gnt[i]=1 means d{i} is consumed this cycle.
- s  out  2  current select (00→d0 … 11→d3); also usable to drive an external 4:1 word mux.
- y  out  WIDTH  selected word.
- yv  out  1  output valid.
- yr  in  1  downstream ready.

## Operation
- State:
  - ptr[1:0]: highest-priority index.
  - lock (1 bit) and lsel[1:0]: held selection.
- Winner search: scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first index with req set wins. If req=0000, there is no winner.
- Priority update on transfer of index k: ptr ← (k+1) mod 4. This wraps 3→0.
- Source rule: a source that raises req[i] holds req[i] and d{i} stable until gnt[i]=1.
- gnt is at most one-hot and is never asserted while clrn=0.
- Default (combinational output) mode:
  - FSM states: IDLE (lock=0) and HOLD (lock=1).
  - IDLE:
    - s = winner (or ptr if no winner); y = d[s]; yv = |req.
    - If yv & yr: gnt[winner]=1, ptr updates, stay IDLE.
    - If yv & !yr: lock←1, lsel←winner, go to HOLD.
  - HOLD:
    - s = lsel; y = d[lsel]; yv=1. New or higher-priority requests are ignored.
    - On yr=1: gnt[lsel]=1, ptr ← lsel+1, lock←0, go to IDLE.
  - Consequence: once yv is raised, y and s stay constant until accepted.
- Reset (clrn=0 at an edge): ptr←0, lock←0, lsel←0. Reset overrides any handshake in the same cycle, including a reset mid-HOLD.
- Reset values with req=0: s=00, yv=0, gnt=0000. y equals d0.

## Timing
- Default mode:
  - Zero-cycle latency: gnt, s, y and yv are combinational from req/yr/state.
  - Throughput: one word per cycle when yr=1 continuously.
  - With req=1111 and yr=1, grant order is 0,1,2,3,0,… one per cycle.
- Fairness: a continuously requesting source is granted within 4 transfers.
- Simultaneous events:
  - A req change during HOLD takes effect in the first IDLE cycle after the accepting edge.
  - Dropping req[lsel] during HOLD is a source protocol violation. Behaviour is then undefined, and the bench flags it.

## Configuration
- ARB_OUTREG_EN defined: registered output stage.
  - y (WIDTH bits) and yv are flops; lock/HOLD is unused.
  - gnt[winner] = (winner exists) & (!yv | yr).
  - On that gnt, y←d[winner] and yv←1 at the next edge.
  - Else, if yr: yv←0.
  - s shows the current winner (combinational); ptr updates on gnt.
  - Latency: 1 cycle from gnt to yv. Full throughput with yr=1.
  - Reset: y←0, yv←0, ptr←0.
- ARB_OUTREG_EN undefined: combinational output with the IDLE/HOLD lock described above.

## Test plan
- Reset:
  - Stimulus: clrn=0 for 2 cycles with req=1111.
  - Required: gnt=0000 and s=00 during reset; yv=0 in registered mode.
  - After release with yr=1: gnt sequence 0001, 0010, 0100, 1000, 0001.
- Lock:
  - Stimulus: req=0100, d2=32'hDEADBEEF, yr=0 for 3 cycles; raise req[0] in cycle 2; then yr=1.
  - Required while yr=0: y=DEADBEEF, s=10, gnt=0000.
  - Required at yr=1: gnt=0100, and the next cycle s=00, gnt=0001.
- Wrap-around:
  - Stimulus: transfer index 2 (ptr becomes 3), then req=1001 with yr=1.
  - Required: grants 1000 then 0001; ptr ends at 1.
- Reset mid-HOLD:
  - Stimulus: lock on d3 (yr=0), then clrn=0 for 1 cycle.
  - Required: no gnt; afterwards ptr=0 and lock=0.
  - With req=1010 and yr=1, the first grant is 0010.
- ARB_OUTREG_EN:
  - Stimulus: req=0001, d0 incrementing from 32'h0, yr=1 for 4 cycles.
  - Required: yv rises 1 cycle after the first gnt; y = 0,1,2,3 on consecutive cycles.
  - Stimulus: then yr=0 for 2 cycles.
  - Required: y holds and gnt=0000.
- Idle:
  - Stimulus: req=0000 for 5 cycles.
  - Required: yv=0, gnt=0000, ptr unchanged.

Source files
------------

// File: rtl/arb4x32.sv
`default_nettype none
// ============================================================================
//  Module      : arb4x32
//  Description : Four-requester round-robin arbiter sharing one WIDTH-bit
//                output channel. Drives the 2-bit select of the shared 4:1
//                word mux and runs valid/ready on both sides.
//                Optional macro ARB_OUTREG_EN selects a registered output
//                stage; when undefined the output is combinational and the
//                selection is locked (HOLD) until the word is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb4x32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] y,
    output logic             yv,
    input  logic             yr
);

    // Highest-priority index for the round-robin scan.
    logic [1:0]       r_ptr;

    // Request vector rotated so bit j corresponds to index (ptr + j) mod 4.
    logic [7:0]       w_rot2;
    logic [3:0]       w_rot;
    logic [1:0]       w_off;
    logic             w_found;
    logic [1:0]       w_win;
    logic [WIDTH-1:0] w_word;

    assign w_rot2  = {req, req} >> r_ptr;
    assign w_rot   = w_rot2[3:0];
    assign w_found = |req;
    // With no request the winner defaults to ptr, which is what s shows idle.
    assign w_win   = r_ptr + w_off;

    // Priority-encode the rotated request: lowest offset from ptr wins.
    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    // Shared 4:1 word multiplexer steered by the current select.
    always_comb begin
        w_word = d0;
        case (s)
            2'd0:    w_word = d0;
            2'd1:    w_word = d1;
            2'd2:    w_word = d2;
            default: w_word = d3;
        endcase
    end

`ifdef ARB_OUTREG_EN

    logic [WIDTH-1:0] r_y;
    logic             r_yv;

    assign y  = r_y;
    assign yv = r_yv;

    // Accept a new word whenever the output register is empty or draining.
    always_comb begin
        s   = w_win;
        gnt = 4'b0000;
        if (w_found && clrn && (!r_yv || yr)) begin
            gnt = 4'b0001 << w_win;
        end
    end

    // Output register and priority pointer; reset wins over any transfer.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_ptr <= 2'd0;
            r_y   <= '0;
            r_yv  <= 1'b0;
        end else if (|gnt) begin
            r_y   <= w_word;
            r_yv  <= 1'b1;
            r_ptr <= w_win + 2'd1;
        end else if (yr) begin
            r_yv  <= 1'b0;
        end
    end

`else

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [1:0] r_lsel;
    logic [1:0] w_lsel_nxt;
    logic [1:0] w_ptr_nxt;

    assign y = w_word;

    // State, pointer and locked-selection registers; reset overrides HOLD.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_lsel  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lsel  <= w_lsel_nxt;
        end
    end

    // Next-state and outputs: offer the winner, lock it if not accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lsel_nxt  = r_lsel;
        s           = w_win;
        yv          = w_found;
        gnt         = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    if (yr) begin
                        gnt       = 4'b0001 << w_win;
                        w_ptr_nxt = w_win + 2'd1;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_lsel_nxt  = w_win;
                    end
                end
            end
            ST_HOLD: begin
                // Newer requests are ignored until the held word is taken.
                s  = r_lsel;
                yv = 1'b1;
                if (yr) begin
                    gnt         = 4'b0001 << r_lsel;
                    w_ptr_nxt   = r_lsel + 2'd1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // No word is consumed while reset is asserted.
        if (!clrn) begin
            gnt = 4'b0000;
        end
    end

`endif

endmodule
`default_nettype wire

// File: tb/tb_arb4x32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb4x32
//  Description : Self-checking bench for arb4x32 (vector table, directed
//                corner sequences, randomized traffic against a model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb4x32;

    logic        clk;
    logic        clrn;
    logic [3:0]  req;
    logic [31:0] d0, d1, d2, d3;
    logic [3:0]  gnt;
    logic [1:0]  s;
    logic [31:0] y;
    logic        yv;
    logic        yr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] nd [4];

    arb4x32 #(.WIDTH(32)) dut (
        .clk (clk),
        .clrn(clrn),
        .req (req),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .gnt (gnt),
        .s   (s),
        .y   (y),
        .yv  (yv),
        .yr  (yr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic c, input logic [3:0] r, input logic ready);
        @(negedge clk);
        clrn = c;
        req  = r;
        yr   = ready;
        d0   = nd[0];
        d1   = nd[1];
        d2   = nd[2];
        d3   = nd[3];
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_ptr;
    int          m_held;
    int          m_win;
    logic [31:0] m_y_r;
    logic        m_yv_r;
    logic [3:0]  m_gnt;
    logic [1:0]  m_s;
    logic        m_yv;
    logic [31:0] m_y;

    function automatic int find_win(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_held = -1;
        m_y_r  = 32'h0;
        m_yv_r = 1'b0;
    endtask

    task automatic model_eval();
        m_win = find_win(req, m_ptr);
`ifdef ARB_OUTREG_EN
        m_s   = 2'((m_win >= 0) ? m_win : m_ptr);
        m_gnt = (m_win >= 0 && clrn && (!m_yv_r || yr)) ? 4'(1 << m_win) : 4'b0000;
        m_yv  = m_yv_r;
        m_y   = m_y_r;
`else
        if (m_held >= 0) begin
            m_s   = 2'(m_held);
            m_yv  = 1'b1;
            m_gnt = (yr && clrn) ? 4'(1 << m_held) : 4'b0000;
        end else begin
            m_s   = 2'((m_win >= 0) ? m_win : m_ptr);
            m_yv  = (m_win >= 0);
            m_gnt = (m_win >= 0 && yr && clrn) ? 4'(1 << m_win) : 4'b0000;
        end
        m_y = nd[m_s];
`endif
    endtask

    task automatic model_adv();
        if (!clrn) begin
            model_reset();
            return;
        end
`ifdef ARB_OUTREG_EN
        if (m_gnt != 4'b0000) begin
            m_y_r  = nd[m_win];
            m_yv_r = 1'b1;
            m_ptr  = (m_win + 1) % 4;
        end else if (yr) begin
            m_yv_r = 1'b0;
        end
`else
        if (m_gnt != 4'b0000) begin
            m_ptr  = (int'(m_s) + 1) % 4;
            m_held = -1;
        end else if (m_held < 0 && m_yv && !yr) begin
            m_held = m_win;
        end
`endif
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       c;
        logic [3:0] r;
        logic       rdy;
        logic [3:0] g;
        logic [1:0] sel;
        logic       v;
    } vec_t;

    vec_t tbl [6];

    int          waited  [4];
    logic        pending [4];
    logic [3:0]  rq;
    int          gi;

    initial begin
        // reset with all sources requesting, then grants rotate 0,1,2,3,0
`ifdef ARB_OUTREG_EN
        tbl[0] = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b0};
`else
        tbl[0] = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b1};
        tbl[1] = '{1'b1, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1};
`endif
        tbl[2] = '{1'b1, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[3] = '{1'b1, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[4] = '{1'b1, 4'hF, 1'b1, 4'b1000, 2'd3, 1'b1};
        tbl[5] = '{1'b1, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1};

        nd[0] = 32'hA0; nd[1] = 32'hA1; nd[2] = 32'hA2; nd[3] = 32'hA3;
        clrn = 1'b0; req = 4'hF; yr = 1'b1;
        d0 = nd[0]; d1 = nd[1]; d2 = nd[2]; d3 = nd[3];
        @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].c, tbl[i].r, tbl[i].rdy);
            check($sformatf("tbl%0d_gnt", i), {28'h0, gnt}, {28'h0, tbl[i].g});
            check($sformatf("tbl%0d_s", i), {30'h0, s}, {30'h0, tbl[i].sel});
            check($sformatf("tbl%0d_yv", i), {31'h0, yv}, {31'h0, tbl[i].v});
        end
        // ptr is now 1

`ifndef ARB_OUTREG_EN
        // lock on d2 while downstream stalls; lower-priority req[0] ignored
        nd[2] = 32'hDEADBEEF;
        drive(1'b1, 4'b0100, 1'b0);
        check("lock_y1", y, 32'hDEADBEEF);
        check("lock_s1", {30'h0, s}, 32'd2);
        check("lock_g1", {28'h0, gnt}, 32'h0);
        drive(1'b1, 4'b0101, 1'b0);
        check("lock_y2", y, 32'hDEADBEEF);
        check("lock_s2", {30'h0, s}, 32'd2);
        check("lock_g2", {28'h0, gnt}, 32'h0);
        drive(1'b1, 4'b0101, 1'b0);
        check("lock_s3", {30'h0, s}, 32'd2);
        check("lock_g3", {28'h0, gnt}, 32'h0);
        drive(1'b1, 4'b0101, 1'b1);
        check("lock_acc", {28'h0, gnt}, 32'b0100);
        drive(1'b1, 4'b0001, 1'b1);
        check("lock_next_s", {30'h0, s}, 32'd0);
        check("lock_next_g", {28'h0, gnt}, 32'b0001);
        // ptr is now 1

        // reset in the middle of a HOLD on d3
        drive(1'b1, 4'b1000, 1'b0);
        check("mh_s", {30'h0, s}, 32'd3);
        check("mh_y", y, 32'hA3);
        drive(1'b1, 4'b1000, 1'b0);
        check("mh_hold_g", {28'h0, gnt}, 32'h0);
        drive(1'b0, 4'b1000, 1'b1);
        check("mh_rst_g", {28'h0, gnt}, 32'h0);
        drive(1'b1, 4'b0000, 1'b1);
        check("mh_ptr0", {30'h0, s}, 32'd0);
        check("mh_unlock", {31'h0, yv}, 32'd0);
        drive(1'b1, 4'b1010, 1'b1);
        check("mh_first", {28'h0, gnt}, 32'b0010);
        drive(1'b1, 4'b1000, 1'b1);
        check("mh_second", {28'h0, gnt}, 32'b1000);
`else
        // registered stream from d0 with incrementing data
        drive(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            nd[0] = 32'(i);
            drive(1'b1, 4'b0001, 1'b1);
            check($sformatf("rs_g%0d", i), {28'h0, gnt}, 32'b0001);
            check($sformatf("rs_yv%0d", i), {31'h0, yv}, (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) check($sformatf("rs_y%0d", i), y, 32'(i - 1));
        end
        nd[0] = 32'd4;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'b0001, 1'b0);
            check($sformatf("rs_stall_y%0d", i), y, 32'd3);
            check($sformatf("rs_stall_g%0d", i), {28'h0, gnt}, 32'h0);
            check($sformatf("rs_stall_v%0d", i), {31'h0, yv}, 32'd1);
        end
        drive(1'b1, 4'b0001, 1'b1);
        check("rs_resume_g", {28'h0, gnt}, 32'b0001);
        check("rs_resume_y", y, 32'd3);
        drive(1'b1, 4'b0000, 1'b1);
        check("rs_last_y", y, 32'd4);
        check("rs_last_v", {31'h0, yv}, 32'd1);
        drive(1'b1, 4'b0000, 1'b1);
        check("rs_drain_v", {31'h0, yv}, 32'd0);
        // ptr is now 1
`endif

        // wrap-around: transfer index 2, then 3 and 0 with ptr wrapping
        nd[0] = 32'hA0; nd[2] = 32'hA2;
        drive(1'b1, 4'b0100, 1'b1);
        check("wrap_g2", {28'h0, gnt}, 32'b0100);
        drive(1'b1, 4'b1001, 1'b1);
        check("wrap_g3", {28'h0, gnt}, 32'b1000);
        drive(1'b1, 4'b0001, 1'b1);
        check("wrap_g0", {28'h0, gnt}, 32'b0001);

        // idle: no requests, pointer (visible on s) must stay at 1
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0000, 1'b1);
            check($sformatf("idle_g%0d", i), {28'h0, gnt}, 32'h0);
            check($sformatf("idle_s%0d", i), {30'h0, s}, 32'd1);
            if (i > 0) check($sformatf("idle_yv%0d", i), {31'h0, yv}, 32'd0);
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 4; i++) begin
            pending[i] = 1'b0;
            waited[i]  = 0;
        end
        drive(1'b0, 4'b0000, 1'b1);
        model_eval();
        check("rnd_rst_g", {28'h0, gnt}, 32'h0);
        model_adv();
        for (int c = 0; c < 2000; c++) begin
            rq = 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if (!pending[i] && ($urandom_range(9) < 4)) begin
                    pending[i] = 1'b1;
                    nd[i]      = $urandom;
                    waited[i]  = 0;
                end
                rq[i] = pending[i];
            end
            drive(1'b1, rq, ($urandom_range(3) != 0));
            model_eval();
            check("rnd_gnt", {28'h0, gnt}, {28'h0, m_gnt});
            check("rnd_s", {30'h0, s}, {30'h0, m_s});
            check("rnd_yv", {31'h0, yv}, {31'h0, m_yv});
            if (m_yv) check("rnd_y", y, m_y);
            if (m_gnt != 4'b0000) begin
                gi = 0;
                for (int i = 0; i < 4; i++) if (m_gnt[i]) gi = i;
                for (int i = 0; i < 4; i++) begin
                    if (pending[i] && i != gi) waited[i]++;
                end
                check("rnd_fair", (waited[gi] <= 3) ? 32'd1 : 32'd0, 32'd1);
                pending[gi] = 1'b0;
                waited[gi]  = 0;
            end
            model_adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
